// File: rtl/bip_pkg.sv
// bip_pkg: opcodes, FSM states, ALU op encoding and decode helpers for bip_multicycle_core
package bip_pkg;
  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_ANDI = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ORI  = 5'b01011;
  localparam logic [4:0] OP_XOR  = 5'b01100;
  localparam logic [4:0] OP_XORI = 5'b01101;
  localparam logic [4:0] OP_JMP  = 5'b01110;
  localparam logic [4:0] OP_BEQ  = 5'b01111;
  localparam logic [4:0] OP_BNE  = 5'b10000;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_e;
  typedef enum logic [2:0] {ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR} alu_op_e;
  function automatic logic is_alu(input logic [4:0] op);
    return op >= OP_LD && op <= OP_XORI;
  endfunction
  function automatic logic is_read(input logic [4:0] op);
    return is_alu(op) && !op[0];
  endfunction
  function automatic logic is_imm(input logic [4:0] op);
    return is_alu(op) && op[0];
  endfunction
  function automatic alu_op_e alu_op_of(input logic [4:0] op);
    return op[4:1] == 4'd2 ? ALU_ADD :
           op[4:1] == 4'd3 ? ALU_SUB :
           op[4:1] == 4'd4 ? ALU_AND :
           op[4:1] == 4'd5 ? ALU_OR  :
           op[4:1] == 4'd6 ? ALU_XOR : ALU_PASS;
  endfunction
endpackage

// File: rtl/bip_alu.sv
// bip_alu: combinational add/sub/and/or/xor/pass-b; ports a_i, b_i, op_i -> y_o
module bip_alu
  import bip_pkg::*;
#(
  parameter int NB_DATA = 16
) (
  input  logic [NB_DATA-1:0] a_i,
  input  logic [NB_DATA-1:0] b_i,
  input  alu_op_e            op_i,
  output logic [NB_DATA-1:0] y_o
);
  assign y_o = op_i == ALU_ADD ? a_i + b_i :
               op_i == ALU_SUB ? a_i - b_i :
               op_i == ALU_AND ? a_i & b_i :
               op_i == ALU_OR  ? a_i | b_i :
               op_i == ALU_XOR ? a_i ^ b_i : b_i;
endmodule

// File: rtl/bip_multicycle_core.sv
// bip_multicycle_core: multi-cycle accumulator core (FETCH/DECODE/EXEC/WB/HALT) over external sync RAMs
// ports: i_clock, i_reset (async high), i_valid stall; o_pc/i_instruction imem; o_data_* /i_data_rd dmem;
// status o_acc, o_instruction, o_retire, o_halted. BIP_BRANCH_EN enables JMP/BEQ/BNE, else they are NOPs.
module bip_multicycle_core
  import bip_pkg::*;
#(
  parameter int NB_DATA            = 16,
  parameter int NB_OPCODE          = 5,
  parameter int NB_OPERAND         = 11,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int LOG2_N_DATA_ADDR   = 10
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_valid,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_pc,
  input  logic [NB_DATA-1:0]            i_instruction,
  output logic [LOG2_N_DATA_ADDR-1:0]   o_data_addr,
  output logic                          o_data_wr_en,
  output logic [NB_DATA-1:0]            o_data_wr,
  input  logic [NB_DATA-1:0]            i_data_rd,
  output logic [NB_DATA-1:0]            o_acc,
  output logic [NB_DATA-1:0]            o_instruction,
  output logic                          o_retire,
  output logic                          o_halted
);
  localparam int NB_EXT = NB_DATA - NB_OPERAND;
  state_e                        state_q, state_d;
  logic [LOG2_N_INSMEM_ADDR-1:0] pc_q, pc_d, pc_nxt;
  logic [NB_DATA-1:0]            acc_q, acc_d, ir_q, ir_d, imm, alu_b, alu_y;
  logic                          retire_q, retire_d;
  logic [NB_OPCODE-1:0]          opc;
  assign opc   = ir_q[NB_DATA-1 -: NB_OPCODE];
  assign imm   = {{NB_EXT{ir_q[NB_OPERAND-1]}}, ir_q[NB_OPERAND-1:0]};
  assign alu_b = state_q == WB ? i_data_rd : imm;
`ifdef BIP_BRANCH_EN
  assign pc_nxt = (opc == OP_JMP || (opc == OP_BEQ && acc_q == '0) || (opc == OP_BNE && acc_q != '0))
                  ? ir_q[LOG2_N_INSMEM_ADDR-1:0] : pc_q + 1'b1;
`else
  assign pc_nxt = pc_q + 1'b1;
`endif
  bip_alu #(.NB_DATA(NB_DATA)) u_alu (
    .a_i (acc_q),
    .b_i (alu_b),
    .op_i(alu_op_of(opc)),
    .y_o (alu_y)
  );
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    ir_d     = ir_q;
    retire_d = i_valid ? 1'b0 : retire_q;
    if (i_valid) begin
      case (state_q)
        FETCH: state_d = DECODE;
        DECODE: begin
          ir_d    = i_instruction;
          state_d = EXEC;
        end
        EXEC: begin
          pc_d     = pc_nxt;
          acc_d    = is_imm(opc) ? alu_y : acc_q;
          retire_d = opc != OP_HLT && !is_read(opc);
          state_d  = opc == OP_HLT ? HALT : is_read(opc) ? WB : FETCH;
        end
        WB: begin
          acc_d    = alu_y;
          retire_d = 1'b1;
          state_d  = FETCH;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      acc_q    <= '0;
      ir_q     <= '0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      ir_q     <= ir_d;
      retire_q <= retire_d;
    end
  end
  assign o_pc          = pc_q;
  assign o_acc         = acc_q;
  assign o_instruction = ir_q;
  assign o_data_addr   = ir_q[LOG2_N_DATA_ADDR-1:0];
  assign o_data_wr     = acc_q;
  assign o_data_wr_en  = i_valid && state_q == EXEC && opc == OP_STO;
  assign o_retire      = retire_q && i_valid;
  assign o_halted      = state_q == HALT;
endmodule

// File: tb/tb_bip_multicycle_core.sv
// tb_bip_multicycle_core: scoreboard bench with sync instruction/data RAM models around the core
module tb_bip_multicycle_core;
  import bip_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, valid = 1'b1;
  logic [10:0] pc;
  logic [15:0] instr, ir, acc, wr, rd;
  logic [9:0]  daddr;
  logic        wr_en, retire, halted;
  logic [15:0] imem [2048];
  logic [15:0] dmem [1024];
  int          n_chk = 0, n_err = 0, cyc = 0, t = 0, wr_cnt = 0, w0 = 0;
  logic [9:0]  lw_addr;
  logic [15:0] lw_data;
  typedef struct {logic [15:0] acc; logic [10:0] pc; int cyc;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  bip_multicycle_core dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_valid      (valid),
    .o_pc         (pc),
    .i_instruction(instr),
    .o_data_addr  (daddr),
    .o_data_wr_en (wr_en),
    .o_data_wr    (wr),
    .i_data_rd    (rd),
    .o_acc        (acc),
    .o_instruction(ir),
    .o_retire     (retire),
    .o_halted     (halted)
  );
  always @(posedge clk) begin
    instr <= imem[pc];
    rd    <= dmem[daddr];
    if (wr_en) begin
      dmem[daddr] <= wr;
      wr_cnt      <= wr_cnt + 1;
      lw_addr     <= daddr;
      lw_data     <= wr;
    end
  end
  always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] v);
    return {op, v};
  endfunction
  task automatic push(input logic [15:0] a, input logic [10:0] p, input int lat);
    exp_t e;
    t += lat;
    e.acc = a;
    e.pc  = p;
    e.cyc = t;
    sb.push_back(e);
  endtask
  always @(negedge clk) begin
    if (!rst && retire) begin
      if (sb.size() == 0) chk("sb_extra_retire", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("ret_acc", acc, e.acc);
        chk("ret_pc", pc, e.pc);
        chk("ret_cycle", cyc, e.cyc);
      end
    end
  end
  task automatic rst_vals();
    chk("rst_pc", pc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_wr", wr, 0);
    chk("rst_misc", {daddr, wr_en, retire, halted}, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    valid = 1'b1;
    sb.delete();
    t = 0;
    for (int i = 0; i < 2048; i++) imem[i] = 16'h0;
    for (int i = 0; i < 1024; i++) dmem[i] = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst_vals();
    rst = 1'b0;
  endtask
  task automatic wait_halt(input logic [10:0] p, input logic [15:0] a);
    int n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("halt_seen", halted, 1);
    chk("halt_cycle", cyc, t + 3);
    chk("halt_pc", pc, p);
    chk("halt_acc", acc, a);
    repeat (4) @(negedge clk);
    chk("halt_frozen", {pc, acc, halted}, {p, a, 1'b1});
    chk("sb_empty", sb.size(), 0);
  endtask
  initial begin
    do_reset();
    imem[0] = ins(OP_LDI, 11'd5);
    push(16'd5, 11'd1, 3);
    wait_halt(11'd2, 16'd5);

    do_reset();
    w0 = wr_cnt;
    imem[0] = ins(OP_LDI, 11'd3);
    imem[1] = ins(OP_STO, 11'd10);
    imem[2] = ins(OP_LD, 11'd10);
    imem[3] = ins(OP_ADD, 11'd10);
    push(16'd3, 11'd1, 3);
    push(16'd3, 11'd2, 3);
    push(16'd3, 11'd3, 4);
    push(16'd6, 11'd4, 4);
    wait_halt(11'd5, 16'd6);
    chk("sto_count", wr_cnt - w0, 1);
    chk("sto_addr", lw_addr, 10);
    chk("sto_data", lw_data, 3);
    chk("dmem10", dmem[10], 3);

    do_reset();
    imem[0]  = ins(OP_LDI, 11'd0);
    imem[1]  = ins(OP_SUBI, 11'd1);
    imem[2]  = ins(OP_ADDI, 11'h7FF);
    imem[3]  = ins(OP_ANDI, 11'h0F0);
    imem[4]  = ins(OP_ORI, 11'h400);
    imem[5]  = ins(OP_XORI, 11'h0FF);
    imem[6]  = ins(OP_STO, 11'd20);
    imem[7]  = ins(OP_LDI, 11'h123);
    imem[8]  = ins(OP_AND, 11'd20);
    imem[9]  = ins(OP_OR, 11'd20);
    imem[10] = ins(OP_XOR, 11'd20);
    imem[11] = ins(OP_SUB, 11'd20);
    push(16'h0000, 11'd1, 3);
    push(16'hFFFF, 11'd2, 3);
    push(16'hFFFE, 11'd3, 3);
    push(16'h00F0, 11'd4, 3);
    push(16'hFCF0, 11'd5, 3);
    push(16'hFC0F, 11'd6, 3);
    push(16'hFC0F, 11'd7, 3);
    push(16'h0123, 11'd8, 3);
    push(16'h0003, 11'd9, 4);
    push(16'hFC0F, 11'd10, 4);
    push(16'h0000, 11'd11, 4);
    push(16'h03F1, 11'd12, 4);
    wait_halt(11'd13, 16'h03F1);

    do_reset();
    imem[0] = ins(OP_LDI, 11'd3);
    imem[1] = ins(OP_SUBI, 11'd1);
    imem[2] = ins(OP_BNE, 11'd1);
    push(16'd3, 11'd1, 3);
    push(16'd2, 11'd2, 3);
`ifdef BIP_BRANCH_EN
    push(16'd2, 11'd1, 3);
    push(16'd1, 11'd2, 3);
    push(16'd1, 11'd1, 3);
    push(16'd0, 11'd2, 3);
    push(16'd0, 11'd3, 3);
    wait_halt(11'd4, 16'd0);
`else
    push(16'd2, 11'd3, 3);
    wait_halt(11'd4, 16'd2);
`endif

    do_reset();
    imem[0] = ins(OP_LDI, 11'd0);
    imem[1] = ins(OP_BEQ, 11'd3);
    imem[2] = ins(OP_LDI, 11'd7);
    imem[3] = ins(OP_JMP, 11'd5);
    imem[4] = ins(OP_LDI, 11'd9);
    push(16'd0, 11'd1, 3);
`ifdef BIP_BRANCH_EN
    push(16'd0, 11'd3, 3);
    push(16'd0, 11'd5, 3);
    wait_halt(11'd6, 16'd0);
`else
    push(16'd0, 11'd2, 3);
    push(16'd7, 11'd3, 3);
    push(16'd7, 11'd4, 3);
    push(16'd9, 11'd5, 3);
    wait_halt(11'd6, 16'd9);
`endif

    do_reset();
    dmem[30] = 16'h1234;
    imem[0]  = ins(OP_LD, 11'd30);
    push(16'h1234, 11'd1, 9);
    repeat (3) @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_pc", pc, 1);
    chk("stall_acc", acc, 0);
    chk("stall_retire", retire, 0);
    valid = 1'b1;
    wait_halt(11'd2, 16'h1234);

    do_reset();
    imem[0] = ins(OP_LDI, 11'd5);
    imem[1] = ins(OP_STO, 11'd40);
    push(16'd5, 11'd1, 3);
    w0 = wr_cnt;
    repeat (5) @(negedge clk);
    chk("sto_exec_wr_en", wr_en, 1);
    chk("sto_exec_addr", daddr, 40);
    #1 rst = 1'b1;
    #1 rst_vals();
    sb.delete();
    repeat (3) @(negedge clk);
    chk("rst_no_write", wr_cnt - w0, 0);
    chk("dmem40", dmem[40], 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
